// File: rtl/dac_bus_arbiter_pkg.sv
// Shared types for the DAC bus arbiter: FSM state encoding.
package dac_bus_arbiter_pkg;

    localparam int unsigned STATE_WID = 2;

    typedef enum logic [STATE_WID-1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StRelease = 2'd2,
        StGap     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1, wrapping.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    int unsigned w_cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        w_cand = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = (32'(last) + k) % N;
            if (!valid && req[IDX_W'(w_cand)]) begin
                valid = 1'b1;
                idx   = IDX_W'(w_cand);
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dac_bus_arbiter.sv
// Round-robin arbiter sharing one DAC SPI master between NREQ requesters,
// with a forced idle gap on the DAC bus between transactions.
module dac_bus_arbiter
    import dac_bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ                 = 3,
    parameter int unsigned DAC_WID              = 24,
    parameter int unsigned DAC_WAIT_BETWEEN_CMD = 10,
    parameter int unsigned TIMER_WID            = 4
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic [NREQ-1:0]         arm,
    input  logic [NREQ*DAC_WID-1:0] to_dac,
    output logic [DAC_WID-1:0]      from_dac,
    output logic [NREQ-1:0]         finished,
    output logic [NREQ-1:0]         grant,
    output logic                    dac_arm,
    output logic [DAC_WID-1:0]      dac_to_dac,
    input  logic [DAC_WID-1:0]      dac_from_dac,
    input  logic                    dac_finished
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam logic [TIMER_WID-1:0] GAP_LAST =
        TIMER_WID'((DAC_WAIT_BETWEEN_CMD == 0) ? 0 : DAC_WAIT_BETWEEN_CMD - 1);

    arb_state_e           r_state, w_state_d;
    logic [NREQ-1:0]      r_grant, w_grant_d;
    logic [IDX_W-1:0]     r_last, w_last_d;
    logic                 r_dac_arm, w_dac_arm_d;
    logic [DAC_WID-1:0]   r_word, w_word_d;
    logic [TIMER_WID-1:0] r_cnt, w_cnt_d;
    logic                 r_abort, w_abort_d;

    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [NREQ-1:0]      w_pick_onehot;
    logic [DAC_WID-1:0]   w_pick_word;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (arm),
        .last   (r_last),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    always_comb begin
        w_pick_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_word = to_dac[i*DAC_WID +: DAC_WID];
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_last_d    = r_last;
        w_dac_arm_d = r_dac_arm;
        w_word_d    = r_word;
        w_cnt_d     = r_cnt;
        w_abort_d   = r_abort;
        case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_grant_d   = w_pick_onehot;
                    w_last_d    = w_pick_idx;
                    w_word_d    = w_pick_word;
                    w_dac_arm_d = 1'b1;
                    w_state_d   = StBusy;
                end
            end
            StBusy: begin
                // An aborted frame still runs to completion; its finished pulse is masked.
                if (!arm[r_last] || r_abort) begin
                    if (dac_finished) begin
                        w_dac_arm_d = 1'b0;
                        w_state_d   = StRelease;
                    end else begin
                        w_abort_d = 1'b1;
                    end
                end
            end
            StRelease: begin
                if (!dac_finished) begin
                    w_grant_d = '0;
                    w_cnt_d   = '0;
                    w_abort_d = 1'b0;
                    w_state_d = (DAC_WAIT_BETWEEN_CMD == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == GAP_LAST) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_grant_d   = '0;
                w_dac_arm_d = 1'b0;
                w_abort_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_last    <= IDX_W'(NREQ - 1);
            r_dac_arm <= 1'b0;
            r_word    <= '0;
            r_cnt     <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_grant   <= w_grant_d;
            r_last    <= w_last_d;
            r_dac_arm <= w_dac_arm_d;
            r_word    <= w_word_d;
            r_cnt     <= w_cnt_d;
            r_abort   <= w_abort_d;
        end
    end

    assign from_dac   = dac_from_dac;
    assign finished   = r_abort ? '0 : (r_grant & {NREQ{dac_finished}});
    assign grant      = r_grant;
    assign dac_arm    = r_dac_arm;
    assign dac_to_dac = r_word;

endmodule
